// File: rtl/icache_refill_assembler_pkg.sv
// Shared definitions for the icache refill assembler.
//   - default line / transaction-ID widths used as module parameter defaults
//   - AXI R-channel response encodings and a helper that flags error responses
//   - refill FSM state type
package icache_refill_assembler_pkg;

    localparam int unsigned ICACHE_LINE_WIDTH = 256;
    localparam int unsigned CACHE_ID_WIDTH    = 4;
    localparam int unsigned AXI_BEAT_WIDTH    = 64;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_RETURN
    } refill_state_e;

    // EXOKAY carries no meaning for instruction fetches and counts as OKAY.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err;
        case (resp)
            AXI_RESP_OKAY, AXI_RESP_EXOKAY:   err = 1'b0;
            AXI_RESP_SLVERR, AXI_RESP_DECERR: err = 1'b1;
            default:                          err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/icache_refill_assembler.sv
// Collects the 64-bit AXI R beats of one icache refill into a full line and
// hands it to the L1I$ as a single-cycle return pulse.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  refill request (sent the cycle AR completes)
//   req_nc_i                 non-cacheable single-beat read
//   req_tid_i, req_axi_id_i  icache transaction ID and AXI ID used on AR
//   kill_i                   discard the current refill; its beats still drain
//   r_*                      AXI R channel (64-bit data)
//   rtrn_vld_o               one-cycle return pulse
//   rtrn_data_o/tid_o/err_o  returned line, tid and error flag; held until the
//                            next return
module icache_refill_assembler
    import icache_refill_assembler_pkg::*;
#(
    parameter int unsigned LineWidth = ICACHE_LINE_WIDTH,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned TidWidth  = CACHE_ID_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_nc_i,
    input  logic [TidWidth-1:0]  req_tid_i,
    input  logic [IdWidth-1:0]   req_axi_id_i,
    input  logic                 kill_i,
    input  logic                 r_valid_i,
    output logic                 r_ready_o,
    input  logic [63:0]          r_data_i,
    input  logic [IdWidth-1:0]   r_id_i,
    input  logic                 r_last_i,
    input  logic [1:0]           r_resp_i,
    output logic                 rtrn_vld_o,
    output logic [LineWidth-1:0] rtrn_data_o,
    output logic [TidWidth-1:0]  rtrn_tid_o,
    output logic                 rtrn_err_o
);

    localparam int unsigned NumWords = LineWidth / AXI_BEAT_WIDTH;
    localparam int unsigned CntWidth = $clog2(NumWords) + 1;
    localparam int unsigned IdxWidth = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam logic [CntWidth-1:0] FullCnt = CntWidth'(NumWords);
    localparam logic [CntWidth-1:0] OneCnt  = CntWidth'(1);

    refill_state_e state_q, state_d;

    logic                nc_q;
    logic [TidWidth-1:0] tid_q;
    logic [IdWidth-1:0]  axi_id_q;
    logic [CntWidth-1:0] expected_q;
    logic [CntWidth-1:0] count_q, count_d;
    logic                err_q, err_d;
    logic                killed_q, killed_d;
    logic [63:0]         words_q [NumWords];
    logic [63:0]         words_d [NumWords];

    logic [LineWidth-1:0] rtrn_data_q;
    logic [TidWidth-1:0]  rtrn_tid_q;
    logic                 rtrn_err_q;

    logic                 req_accept;
    logic                 beat;
    logic                 in_range;
    logic [IdxWidth-1:0]  beat_idx;
    logic                 load_rtrn;
    logic [LineWidth-1:0] line_d;

    assign req_accept = req_valid_i && (state_q != ST_COLLECT);
    assign beat       = r_valid_i && (state_q == ST_COLLECT);
    assign in_range   = count_q < expected_q;
    assign beat_idx   = nc_q ? '0 : count_q[IdxWidth-1:0];

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        load_rtrn = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (beat && r_last_i) begin
                    // A kill arriving with the last beat still suppresses it.
                    if (killed_q || kill_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_RETURN;
                        load_rtrn = 1'b1;
                    end
                end
            end
            ST_RETURN: begin
                state_d = req_valid_i ? ST_COLLECT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Beat collection datapath
    // ------------------------------------------------------------------
    always_comb begin
        words_d  = words_q;
        count_d  = count_q;
        err_d    = err_q;
        killed_d = killed_q;
        line_d   = '0;

        if (req_accept) begin
            for (int unsigned i = 0; i < NumWords; i++) words_d[i] = '0;
            count_d  = '0;
            err_d    = 1'b0;
            killed_d = 1'b0;
        end else if (state_q == ST_COLLECT) begin
            if (kill_i) killed_d = 1'b1;
            if (beat) begin
                for (int unsigned i = 0; i < NumWords; i++) begin
                    if (in_range && (beat_idx == IdxWidth'(i))) words_d[i] = r_data_i;
                end
                if (in_range) count_d = count_q + OneCnt;
                // Excess beats are dropped but poison the line.
                if (resp_is_err(r_resp_i) || (r_id_i != axi_id_q) || !in_range) err_d = 1'b1;
                // count_d already includes this beat, so this is the short-burst test.
                if (r_last_i && (count_d < expected_q)) err_d = 1'b1;
            end
        end

        // Packed view including the beat landing this cycle, so the return
        // register can be loaded on the last handshake.
        for (int unsigned i = 0; i < NumWords; i++) line_d[i*64 +: 64] = words_d[i];
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            nc_q       <= 1'b0;
            tid_q      <= '0;
            axi_id_q   <= '0;
            expected_q <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            killed_q   <= 1'b0;
            for (int unsigned i = 0; i < NumWords; i++) words_q[i] <= '0;
            rtrn_data_q <= '0;
            rtrn_tid_q  <= '0;
            rtrn_err_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            err_q    <= err_d;
            killed_q <= killed_d;
            words_q  <= words_d;
            if (req_accept) begin
                nc_q       <= req_nc_i;
                tid_q      <= req_tid_i;
                axi_id_q   <= req_axi_id_i;
                expected_q <= req_nc_i ? OneCnt : FullCnt;
            end
            if (load_rtrn) begin
                rtrn_data_q <= line_d;
                rtrn_tid_q  <= tid_q;
                rtrn_err_q  <= err_d;
            end
        end
    end

    assign req_ready_o = (state_q != ST_COLLECT);
    assign r_ready_o   = (state_q == ST_COLLECT);
    assign rtrn_vld_o  = (state_q == ST_RETURN);
    assign rtrn_data_o = rtrn_data_q;
    assign rtrn_tid_o  = rtrn_tid_q;
    assign rtrn_err_o  = rtrn_err_q;

endmodule
